// File: rtl/generador_tablero.sv
// generador_tablero: clears the 8x8 bomb matrix, places LFSR-chosen bombs (code 15), then latches the counted board.
// Latency: 1 clear cycle + 1 cycle per placement attempt + WAIT_CICLOS count cycles until done.
// start/cargar_semilla are ignored (not queued) while busy. SAFE_FIRST_CLICK_EN keeps one chosen cell bomb-free.
module generador_tablero #(
  parameter logic [15:0] SEMILLA_DEF  = 16'hACE1,
  parameter int          WAIT_CICLOS  = 2,
  parameter int          MAX_INTENTOS = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [6:0]           num_bombas,
  input  logic                 cargar_semilla,
  input  logic [15:0]          semilla,
  input  logic [2:0]           safe_fila,
  input  logic [2:0]           safe_col,
  output logic [7:0][7:0][3:0] matrizBombastic,
  input  logic [7:0][7:0][3:0] matrizNumeros,
  output logic [7:0][7:0][3:0] tablero,
  output logic                 busy,
  output logic                 done,
  output logic                 valido,
  output logic                 error_intentos,
  output logic [6:0]           bombas_colocadas
);

`ifdef SAFE_FIRST_CLICK_EN
  localparam logic [6:0] LIMITE = 7'd63;
`else
  localparam logic [6:0] LIMITE = 7'd64;
`endif
  localparam int CW = $clog2(WAIT_CICLOS + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, DONE} estado_t;
  estado_t estado;

  logic [15:0]   lfsr;
  logic [15:0]   lfsr_sig;
  logic [6:0]    objetivo;
  logic [6:0]    colocadas_sig;
  logic [9:0]    intentos;
  logic [9:0]    intentos_sig;
  logic [CW-1:0] espera;
  logic [2:0]    fila;
  logic [2:0]    col;
  logic          excluida;
  logic          libre;

  assign fila = lfsr[5:3];
  assign col  = lfsr[2:0];

`ifdef SAFE_FIRST_CLICK_EN
  logic [2:0] safe_fila_q;
  logic [2:0] safe_col_q;
  assign excluida = (fila == safe_fila_q) && (col == safe_col_q);
`else
  logic unused_safe;
  assign unused_safe = ^{safe_fila, safe_col};
  assign excluida    = 1'b0;
`endif

  assign lfsr_sig      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign libre         = (matrizBombastic[fila][col] != 4'hF) && !excluida;
  assign colocadas_sig = bombas_colocadas + {6'd0, libre};
  assign intentos_sig  = intentos + 10'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado           <= IDLE;
      matrizBombastic  <= '0;
      tablero          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      valido           <= 1'b0;
      error_intentos   <= 1'b0;
      bombas_colocadas <= 7'd0;
      lfsr             <= SEMILLA_DEF;
      objetivo         <= 7'd0;
      intentos         <= 10'd0;
      espera           <= '0;
`ifdef SAFE_FIRST_CLICK_EN
      safe_fila_q      <= 3'd0;
      safe_col_q       <= 3'd0;
`endif
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE, DONE: begin
          if (start) begin
            objetivo       <= (num_bombas > LIMITE) ? LIMITE : num_bombas;
            valido         <= 1'b0;
            error_intentos <= 1'b0;
            busy           <= 1'b1;
            estado         <= CLEAR;
`ifdef SAFE_FIRST_CLICK_EN
            safe_fila_q    <= safe_fila;
            safe_col_q     <= safe_col;
`endif
          end else if (cargar_semilla) begin
            // An all-zero LFSR would lock up, so a zero seed falls back to the default.
            lfsr <= (semilla == 16'd0) ? SEMILLA_DEF : semilla;
          end
        end
        CLEAR: begin
          matrizBombastic  <= '0;
          bombas_colocadas <= 7'd0;
          intentos         <= 10'd0;
          espera           <= CW'(1);
          estado           <= (objetivo == 7'd0) ? COUNT : PLACE;
        end
        PLACE: begin
          lfsr             <= lfsr_sig;
          intentos         <= intentos_sig;
          bombas_colocadas <= colocadas_sig;
          if (libre) matrizBombastic[fila][col] <= 4'hF;
          if (colocadas_sig == objetivo) begin
            estado <= COUNT;
          end else if (intentos_sig == 10'(MAX_INTENTOS)) begin
            error_intentos <= 1'b1;
            estado         <= COUNT;
          end
        end
        COUNT: begin
          // The counter is registered, so its output is only trustworthy from the second COUNT cycle.
          if (espera == CW'(WAIT_CICLOS)) begin
            tablero <= matrizNumeros;
            done    <= 1'b1;
            valido  <= 1'b1;
            busy    <= 1'b0;
            estado  <= DONE;
          end else begin
            espera <= espera + CW'(1);
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generador_tablero.sv
// Directed bench for generador_tablero with a behavioural registered bomb counter and an LFSR placement model.
`timescale 1ns/1ps
module tb_generador_tablero;
  localparam logic [15:0] DEF = 16'hACE1;
`ifdef SAFE_FIRST_CLICK_EN
  localparam int LIMITE   = 63;
  localparam int SAFE_IDX = 3 * 8 + 4;
`else
  localparam int LIMITE   = 64;
  localparam int SAFE_IDX = -1;
`endif
  typedef logic [7:0][7:0][3:0] mat_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       cargar_semilla = 1'b0;
  logic [6:0] num_bombas = 7'd0;
  logic [15:0] semilla = 16'd0;
  logic [2:0] safe_fila = 3'd3;
  logic [2:0] safe_col = 3'd4;
  mat_t       mb1, mn1, tab1, mb2, mn2, tab2;
  logic       busy1, done1, valido1, err1, busy2, done2, valido2, err2;
  logic [6:0] col1, col2;
  int         tests = 0;
  int         fails = 0;

  always #5 clock = ~clock;

  generador_tablero dut1 (
    .clock(clock), .reset(reset), .start(start), .num_bombas(num_bombas),
    .cargar_semilla(cargar_semilla), .semilla(semilla), .safe_fila(safe_fila), .safe_col(safe_col),
    .matrizBombastic(mb1), .matrizNumeros(mn1), .tablero(tab1), .busy(busy1), .done(done1),
    .valido(valido1), .error_intentos(err1), .bombas_colocadas(col1));

  generador_tablero #(.MAX_INTENTOS(20)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .num_bombas(num_bombas),
    .cargar_semilla(cargar_semilla), .semilla(semilla), .safe_fila(safe_fila), .safe_col(safe_col),
    .matrizBombastic(mb2), .matrizNumeros(mn2), .tablero(tab2), .busy(busy2), .done(done2),
    .valido(valido2), .error_intentos(err2), .bombas_colocadas(col2));

  function automatic mat_t contar(input mat_t m);
    mat_t r;
    int   n;
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++) begin
        if (m[f][c] == 4'hF) r[f][c] = 4'hF;
        else begin
          n = 0;
          for (int df = -1; df <= 1; df++)
            for (int dc = -1; dc <= 1; dc++)
              if ((df != 0 || dc != 0) && f + df >= 0 && f + df < 8 && c + dc >= 0 && c + dc < 8)
                if (m[f+df][c+dc] == 4'hF) n++;
          r[f][c] = 4'(n);
        end
      end
    return r;
  endfunction

  function automatic mat_t de_mascara(input logic [63:0] mask);
    mat_t m;
    for (int i = 0; i < 64; i++) m[i/8][i%8] = mask[i] ? 4'hF : 4'h0;
    return m;
  endfunction

  function automatic int cuenta15(input mat_t m);
    int n = 0;
    for (int i = 0; i < 64; i++) if (m[i/8][i%8] == 4'hF) n++;
    return n;
  endfunction

  // Environment: registered neighbour counter with one cycle of latency.
  always @(posedge clock) begin
    mn1 <= contar(mb1);
    mn2 <= contar(mb2);
  end

  task automatic modelo(input logic [15:0] seed, input int n, input int maxi,
                        output logic [63:0] mask, output int puestos, output int intentos, output bit err);
    logic [15:0] l;
    int obj;
    l = (seed == 16'd0) ? DEF : seed;
    obj = (n > LIMITE) ? LIMITE : n;
    mask = '0; puestos = 0; intentos = 0; err = 1'b0;
    while (puestos < obj && !err) begin
      if (!mask[l[5:0]] && int'(l[5:0]) != SAFE_IDX) begin
        mask[l[5:0]] = 1'b1;
        puestos++;
      end
      intentos++;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      if (puestos < obj && intentos == maxi) err = 1'b1;
    end
  endtask

  task automatic cargar(input logic [15:0] s);
    @(negedge clock); semilla = s; cargar_semilla = 1'b1;
    @(negedge clock); cargar_semilla = 1'b0;
  endtask

  task automatic lanzar(input bit sel, input logic [6:0] n, output int ciclos);
    @(negedge clock); num_bombas = n;
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clock); start = 1'b0; start2 = 1'b0; ciclos = 0;
    while (!(sel ? done2 : done1) && ciclos < 3000) begin @(negedge clock); ciclos++; end
    tests++;
    if (ciclos >= 3000) begin fails++; $display("FAIL done_timeout: waited %0d cycles, required done within 3000", ciclos); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    tests++; if (mb1 !== '0) begin fails++; $display("FAIL reset_matriz: got %h required 0", mb1); end
    tests++; if (tab1 !== '0) begin fails++; $display("FAIL reset_tablero: got %h required 0", tab1); end
    tests++; if ({busy1, done1, valido1, err1} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b required 0000", {busy1, done1, valido1, err1}); end
    tests++; if (col1 !== 7'd0) begin fails++; $display("FAIL reset_colocadas: got %0d required 0", col1); end
    tests++; if (dut1.lfsr !== DEF) begin fails++; $display("FAIL reset_lfsr: got %h required %h", dut1.lfsr, DEF); end
  endtask

  task automatic test_cero;
    int c;
    lanzar(1'b0, 7'd0, c);
    tests++; if (c !== 3) begin fails++; $display("FAIL cero_latencia: got %0d required 3", c); end
    tests++; if (tab1 !== '0) begin fails++; $display("FAIL cero_tablero: got %h required 0", tab1); end
    tests++; if (col1 !== 7'd0) begin fails++; $display("FAIL cero_colocadas: got %0d required 0", col1); end
    tests++; if ({busy1, valido1} !== 2'b01) begin fails++; $display("FAIL cero_estado: busy,valido got %b required 01", {busy1, valido1}); end
  endtask

  task automatic test_diez;
    int c, puestos, att;
    bit err;
    logic [63:0] mask;
    cargar(16'h0001);
    modelo(16'h0001, 10, 1023, mask, puestos, att, err);
    lanzar(1'b0, 7'd10, c);
    tests++; if (c !== 3 + att) begin fails++; $display("FAIL diez_latencia: got %0d required %0d", c, 3 + att); end
    tests++; if (col1 !== 7'd10) begin fails++; $display("FAIL diez_colocadas: got %0d required 10", col1); end
    tests++; if (cuenta15(tab1) !== 10) begin fails++; $display("FAIL diez_bombas: got %0d required 10", cuenta15(tab1)); end
    tests++; if (mb1 !== de_mascara(mask)) begin fails++; $display("FAIL diez_matriz: got %h required %h", mb1, de_mascara(mask)); end
    tests++; if (tab1 !== contar(de_mascara(mask))) begin fails++; $display("FAIL diez_tablero: got %h required %h", tab1, contar(de_mascara(mask))); end
    tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL diez_error: got %b required 0", err1); end
    @(negedge clock);
    tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL diez_pulso: done got %b required 0 one cycle later", done1); end
    repeat (5) @(negedge clock);
    tests++; if (valido1 !== 1'b1) begin fails++; $display("FAIL diez_valido: got %b required 1", valido1); end
  endtask

  task automatic test_lleno;
    int c, puestos, att;
    bit err;
    logic [63:0] mask;
    mat_t lleno;
    lleno = '1;
    cargar(16'h1234);
    modelo(16'h1234, 100, 1023, mask, puestos, att, err);
    lanzar(1'b0, 7'd100, c);
    tests++; if (col1 !== 7'(LIMITE)) begin fails++; $display("FAIL lleno_colocadas: got %0d required %0d", col1, LIMITE); end
    tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL lleno_error: got %b required 0", err1); end
    tests++; if (c !== 3 + att) begin fails++; $display("FAIL lleno_latencia: got %0d required %0d", c, 3 + att); end
`ifdef SAFE_FIRST_CLICK_EN
    tests++; if (tab1 !== contar(de_mascara(mask))) begin fails++; $display("FAIL lleno_tablero: got %h required %h", tab1, contar(de_mascara(mask))); end
`else
    tests++; if (tab1 !== lleno) begin fails++; $display("FAIL lleno_tablero: got %h required %h", tab1, lleno); end
`endif
  endtask

  task automatic test_intentos;
    int c, puestos, att;
    bit err;
    logic [63:0] mask;
    cargar(16'h0001);
    modelo(16'h0001, 64, 20, mask, puestos, att, err);
    lanzar(1'b1, 7'd64, c);
    tests++; if (err2 !== 1'b1) begin fails++; $display("FAIL intentos_error: got %b required 1", err2); end
    tests++; if (col2 !== 7'(puestos)) begin fails++; $display("FAIL intentos_colocadas: got %0d required %0d", col2, puestos); end
    tests++; if (!(col2 < 7'd64)) begin fails++; $display("FAIL intentos_menor: got %0d required below 64", col2); end
    tests++; if (c !== 23) begin fails++; $display("FAIL intentos_latencia: got %0d required 23", c); end
    tests++; if (tab2 !== contar(de_mascara(mask))) begin fails++; $display("FAIL intentos_tablero: got %h required %h", tab2, contar(de_mascara(mask))); end
    lanzar(1'b1, 7'd0, c);
    tests++; if ({err2, valido2} !== 2'b01) begin fails++; $display("FAIL intentos_borrado: error,valido got %b required 01", {err2, valido2}); end
  endtask

  task automatic test_ocupado;
    int c, puestos, att;
    bit err;
    logic [63:0] mask;
    mat_t viejo;
    cargar(16'h00FF);
    modelo(16'h00FF, 30, 1023, mask, puestos, att, err);
    @(negedge clock); num_bombas = 7'd30; start = 1'b1;
    @(negedge clock); start = 1'b0; c = 0;
    repeat (3) begin @(negedge clock); c++; end
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL ocupado_busy: got %b required 1", busy1); end
    num_bombas = 7'd5; start = 1'b1; semilla = 16'h0000; cargar_semilla = 1'b1;
    @(negedge clock); c++;
    start = 1'b0; cargar_semilla = 1'b0;
    while (!done1 && c < 3000) begin @(negedge clock); c++; end
    tests++; if (c !== 3 + att) begin fails++; $display("FAIL ocupado_latencia: got %0d required %0d", c, 3 + att); end
    tests++; if (col1 !== 7'd30) begin fails++; $display("FAIL ocupado_colocadas: got %0d required 30", col1); end
    tests++; if (tab1 !== contar(de_mascara(mask))) begin fails++; $display("FAIL ocupado_tablero: got %h required %h", tab1, contar(de_mascara(mask))); end
    cargar(16'h0000);
    tests++; if (dut1.lfsr !== DEF) begin fails++; $display("FAIL semilla_cero: got %h required %h", dut1.lfsr, DEF); end
    viejo = tab1;
    cargar(16'hBEEF);
    @(negedge clock); num_bombas = 7'd50; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    tests++; if (tab1 !== viejo || mb1 === '0) begin fails++; $display("FAIL medio_place: tablero %h matriz %h required old tablero %h and bombs present", tab1, mb1, viejo); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++; if ({mb1, tab1} !== '0) begin fails++; $display("FAIL reset_place_mat: got %h required 0", {mb1, tab1}); end
    tests++; if ({busy1, done1, valido1, err1, col1} !== 11'd0) begin fails++; $display("FAIL reset_place_flags: got %b required 0", {busy1, done1, valido1, err1, col1}); end
    tests++; if (dut1.lfsr !== DEF) begin fails++; $display("FAIL reset_place_lfsr: got %h required %h", dut1.lfsr, DEF); end
  endtask

`ifdef SAFE_FIRST_CLICK_EN
  task automatic test_seguro;
    int c;
    for (int k = 1; k <= 20; k++) begin
      cargar(16'(k * 16'h1357 + 1));
      lanzar(1'b0, 7'd63, c);
      tests++; if (tab1[3][4] === 4'hF || col1 !== 7'd63) begin fails++; $display("FAIL seguro_%0d: celda %h colocadas %0d required not F and 63", k, tab1[3][4], col1); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_cero;
    test_diez;
    test_lleno;
    test_intentos;
    test_ocupado;
`ifdef SAFE_FIRST_CLICK_EN
    test_seguro;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
